// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture block: FSM encoding, default
// image geometry, synchroniser depth and a saturating counter helper.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int SYNC_DEPTH     = 2;
  localparam int CNT_W          = 11;
  localparam int CAM_W          = 8;
  localparam int PIX_W          = 16;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera parallel port bundle: the sensor drives it, the capture block samples it.
interface ov7670_capture_if;
  import ov7670_capture_pkg::*;

  logic             pclk;
  logic             href;
  logic             vsync;
  logic [CAM_W-1:0] data;

  modport master (output pclk, output href, output vsync, output data);
  modport slave  (input  pclk, input  href, input  vsync, input  data);

endinterface

// File: rtl/pixel_fifo_fwft.sv
// First-word-fall-through pixel FIFO. The head word is presented
// combinationally; an empty FIFO presents zero.
module pixel_fifo_fwft
  import ov7670_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [PIX_W-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ovf_evt,
  output logic             udf_evt
);

  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]  wptr;
  logic [ADDR_W:0]  rptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // when it is being read.
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign ovf_evt = wr_en & full & ~rd_ok;
  assign udf_evt = rd_en & empty;

  assign rd_data = empty ? '0 : mem[rptr[ADDR_W-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Storage array, written only when the write is accepted.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture stage: oversamples the camera port, assembles byte pairs
// into {second, first} pixel words, checks frame geometry and buffers the
// words for the display controller.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  ov7670_capture_if.slave  cam,
  input  logic             Capture_En_i,
  input  logic             Read_En_i,
  output logic [PIX_W-1:0] Pixel_o,
  output logic             Frame_Valid_o,
  output logic             Fifo_Empty_o,
  output logic             Overflow_o,
  output logic             Underflow_o,
  output logic             Frame_Error_o
);

  localparam int SYNC_W = CAM_W + 3;
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(IMG_HEIGHT);

  logic [SYNC_W-1:0] sync_q [SYNC_DEPTH];
  logic [SYNC_W-1:0] cam_raw;
  logic [SYNC_W-1:0] cam_s2;
  logic [2:0]        ctl_s3;
  logic              pclk_rise, href_fall, vs_rise, vs_fall;
  logic [CAM_W-1:0]  data_s2;

  cap_state_e        state_q, state_d;
  logic              frame_start, frame_end, in_capture, byte_acc, line_end;

  logic              toggle;
  logic [CAM_W-1:0]  lo_byte;
  logic              wr_vld_p0;
  logic [PIX_W-1:0]  wr_word_p0;
  logic [CNT_W-1:0]  pix_cnt, line_cnt;
  logic              frame_valid, ovf_flag, udf_flag, err_flag;

  logic              fifo_full_unused, fifo_empty, fifo_ovf_evt, fifo_udf_evt;

  assign cam_raw = {cam.data, cam.vsync, cam.href, cam.pclk};

  // Two-flop synchroniser for every camera line plus one extra stage on the
  // control lines for edge detection.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
      ctl_s3 <= '0;
    end else begin
      sync_q[0] <= cam_raw;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
      ctl_s3 <= sync_q[SYNC_DEPTH-1][2:0];
    end
  end

  assign cam_s2    = sync_q[SYNC_DEPTH-1];
  assign data_s2   = cam_s2[SYNC_W-1:3];
  assign pclk_rise =  cam_s2[0] & ~ctl_s3[0];
  assign href_fall = ~cam_s2[1] &  ctl_s3[1];
  assign vs_rise   =  cam_s2[2] & ~ctl_s3[2];
  assign vs_fall   = ~cam_s2[2] &  ctl_s3[2];

  assign in_capture = (state_q == ST_CAPTURE);
  assign byte_acc   = in_capture & pclk_rise & cam_s2[1];
  assign line_end   = in_capture & href_fall;

  // FSM state register.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; once CAPTURE is entered the frame always runs to VSYNC.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE:    if (Capture_En_i) state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_fall) begin
                    frame_start = 1'b1;
                    state_d     = ST_CAPTURE;
                  end
      ST_CAPTURE: if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = ST_DONE;
                  end
      ST_DONE:    state_d = Capture_En_i ? ST_WAIT_VS : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte assembly, write request stage and pixel/line counters.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      toggle     <= 1'b0;
      lo_byte    <= '0;
      wr_vld_p0  <= 1'b0;
      wr_word_p0 <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
    end else begin
      wr_vld_p0 <= 1'b0;
      if (state_q == ST_IDLE || frame_start) begin
        toggle   <= 1'b0;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end
      if (byte_acc) begin
        toggle <= ~toggle;
        if (!toggle) begin
          lo_byte <= data_s2;
        end else begin
          wr_vld_p0  <= 1'b1;
          wr_word_p0 <= {data_s2, lo_byte};
          pix_cnt    <= sat_inc(pix_cnt);
        end
      end
      if (line_end) begin
        line_cnt <= sat_inc(line_cnt);
        pix_cnt  <= '0;
        toggle   <= 1'b0;
      end
    end
  end

  // Frame-valid and sticky status flags; a new event wins over the clear.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      frame_valid <= 1'b0;
      ovf_flag    <= 1'b0;
      udf_flag    <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      if (frame_end)                     frame_valid <= 1'b0;
      else if (wr_vld_p0 && in_capture)  frame_valid <= 1'b1;
      if (frame_start) begin
        ovf_flag <= 1'b0;
        udf_flag <= 1'b0;
        err_flag <= 1'b0;
      end
      if (fifo_ovf_evt) ovf_flag <= 1'b1;
      if (fifo_udf_evt) udf_flag <= 1'b1;
      if (line_end && pix_cnt != WIDTH_C)    err_flag <= 1'b1;
      if (frame_end && line_cnt != HEIGHT_C) err_flag <= 1'b1;
    end
  end

  pixel_fifo_fwft #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk     (Clk_i),
    .rst_n   (Reset_i),
    .wr_en   (wr_vld_p0),
    .wr_data (wr_word_p0),
    .rd_en   (Read_En_i),
    .rd_data (Pixel_o),
    .full    (fifo_full_unused),
    .empty   (fifo_empty),
    .ovf_evt (fifo_ovf_evt),
    .udf_evt (fifo_udf_evt)
  );

  assign Fifo_Empty_o  = fifo_empty;
  assign Frame_Valid_o = frame_valid;
  assign Overflow_o    = ovf_flag;
  assign Underflow_o   = udf_flag;
  assign Frame_Error_o = err_flag;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture with a small frame geometry and FIFO so whole
// frames and overflow fit in a short run. Expected words live in a queue.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int D  = 16;
  localparam int AW = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cap_en = 1'b0;
  logic        rd_en  = 1'b0;
  logic [15:0] pixel;
  logic        fv, empty, ovf, udf, ferr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents, sticky flags and frame bookkeeping.
  logic [15:0] q[$];
  bit m_ovf, m_udf, m_ferr, m_fv, m_capt, m_armed;
  int m_pix, m_lines;

  ov7670_capture_if cam();

  ov7670_capture #(
    .IMG_WIDTH (W), .IMG_HEIGHT (H), .FIFO_DEPTH (D), .ADDR_W (AW)
  ) dut (
    .Clk_i (clk), .Reset_i (rst_n), .cam (cam),
    .Capture_En_i (cap_en), .Read_En_i (rd_en),
    .Pixel_o (pixel), .Frame_Valid_o (fv), .Fifo_Empty_o (empty),
    .Overflow_o (ovf), .Underflow_o (udf), .Frame_Error_o (ferr)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check1 ({tag, "_empty"}, empty, q.size() == 0);
    check16({tag, "_pixel"}, pixel, (q.size() != 0) ? q[0] : 16'h0000);
    check1 ({tag, "_ovf"},   ovf,   m_ovf);
    check1 ({tag, "_udf"},   udf,   m_udf);
    check1 ({tag, "_ferr"},  ferr,  m_ferr);
    check1 ({tag, "_fv"},    fv,    m_fv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam.data = b;
    #20 cam.pclk = 1'b1;
    #20 cam.pclk = 1'b0;
  endtask

  // One pixel; optionally a pop lands on the same clock edge as its write.
  task automatic send_pixel(input bit pop);
    logic [7:0] lo, hi;
    lo = 8'($urandom);
    hi = 8'($urandom);
    send_byte(lo);
    send_byte(hi);
    #10;
    if (pop) begin
      if (q.size() != 0) begin
        check16("pop_head", pixel, q[0]);
        void'(q.pop_front());
      end else begin
        check1("pop_empty", empty, 1'b1);
        m_udf = 1'b1;
      end
      rd_en = 1'b1;
    end
    #10 rd_en = 1'b0;
    if (m_capt) begin
      m_pix++;
      m_fv = 1'b1;
      if (q.size() < D) q.push_back({hi, lo});
      else              m_ovf = 1'b1;
    end
  endtask

  task automatic line_end();
    cam.href = 1'b0;
    #40;
    if (m_capt) begin
      if (m_pix != W) m_ferr = 1'b1;
      m_lines++;
      m_pix = 0;
    end
  endtask

  task automatic line(input int n, input int pop_idx);
    cam.href = 1'b1;
    for (int i = 0; i < n; i++) send_pixel(i == pop_idx);
    line_end();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() != 0) begin
        check16("rd_data", pixel, q[0]);
        void'(q.pop_front());
      end else begin
        check16("rd_empty_pixel", pixel, 16'h0000);
        m_udf = 1'b1;
      end
      rd_en = 1'b1;
      #10;
    end
    rd_en = 1'b0;
    #10;
  endtask

  task automatic vs_fall();
    cam.vsync = 1'b0;
    #40;
    if (m_armed) begin
      m_capt = 1'b1; m_armed = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0; m_ferr = 1'b0; m_fv = 1'b0;
      m_lines = 0; m_pix = 0;
    end
  endtask

  task automatic vs_rise();
    cam.vsync = 1'b1;
    #20;
    check1("fv_before_end", fv, m_fv);
    #10;
    if (m_capt) begin
      if (m_lines != H) m_ferr = 1'b1;
      m_capt  = 1'b0;
      m_armed = cap_en;
    end
    m_fv = 1'b0;
    check1("fv_after_end", fv, 1'b0);
    #20;
  endtask

  task automatic set_en(input logic b);
    cap_en = b;
    if (b && !m_capt) m_armed = 1'b1;
    #20;
  endtask

  initial begin
    cam.pclk = 1'b0; cam.href = 1'b0; cam.vsync = 1'b1; cam.data = 8'h00;
    #30;
    check_all("reset");
    rst_n = 1'b1;
    #40;
    check_all("idle");
    set_en(1'b1);

    // Clean frame, with the 4-cycle write latency on the first pixel.
    vs_fall();
    check_all("clean_start");
    cam.href = 1'b1;
    send_byte(8'hA5);
    cam.data = 8'h3C;
    #20 cam.pclk = 1'b1;
    #20 cam.pclk = 1'b0;
    #10;
    check1("lat_empty_3cyc", empty, 1'b1);
    #10;
    check1("lat_empty_4cyc", empty, 1'b0);
    check16("lat_pixel", pixel, 16'h3CA5);
    q.push_back(16'h3CA5);
    m_pix++;
    m_fv = 1'b1;
    for (int i = 1; i < W; i++) send_pixel(1'b0);
    line_end();
    check_all("clean_l0");
    drain(q.size());
    for (int l = 1; l < H; l++) begin
      line(W, -1);
      check_all("clean_line");
      drain(q.size());
    end
    vs_rise();
    check_all("clean_end");

    // Short line flags an error that clears at the next frame start.
    vs_fall();
    line(W, -1);
    line(W - 1, -1);
    check_all("short_err");
    drain(q.size());
    line(W, -1);
    line(W, -1);
    drain(q.size());
    vs_rise();
    check_all("short_end");
    vs_fall();
    check_all("short_clr");

    // Same frame with no reads: FIFO fills, the rest is dropped.
    for (int l = 0; l < H; l++) line(W, -1);
    vs_rise();
    check_all("ovf");
    drain(D);
    check_all("ovf_drained");
    drain(1);
    check_all("udf");

    // Full FIFO with a pop on the same edge as a write.
    vs_fall();
    check_all("full_start");
    line(W, -1);
    line(W, -1);
    check_all("full");
    line(1, 0);
    check_all("full_pop");
    vs_rise();
    drain(D);
    check_all("full_drained");

    // Randomised frames: data, occasional short lines, pops and partial drains.
    for (int f = 0; f < 3; f++) begin
      vs_fall();
      check_all("rnd_start");
      for (int l = 0; l < H; l++) begin
        int n, p;
        n = ($urandom_range(0, 4) == 0) ? W - 1 : W;
        p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
        line(n, p);
        if ($urandom_range(0, 1) == 1) drain(int'($urandom_range(0, q.size())));
        check_all("rnd_line");
      end
      vs_rise();
      check_all("rnd_end");
    end

    // Reset in the middle of a line, then stay idle with capture disabled.
    vs_fall();
    cam.href = 1'b1;
    for (int i = 0; i < 3; i++) send_pixel(1'b0);
    rst_n = 1'b0;
    cam.href = 1'b0;
    #10;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_ferr = 1'b0; m_fv = 1'b0;
    m_capt = 1'b0; m_armed = 1'b0; m_pix = 0; m_lines = 0;
    check_all("rst_mid");
    cap_en = 1'b0;
    #20 rst_n = 1'b1;
    #20;
    vs_rise();
    vs_fall();
    line(W, -1);
    check_all("rst_idle");
    vs_rise();
    check_all("rst_idle_end");

    // Recovery once capture is enabled again.
    set_en(1'b1);
    vs_fall();
    for (int l = 0; l < H; l++) begin
      line(W, -1);
      drain(q.size());
    end
    vs_rise();
    check_all("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
